// File: rtl/redtin_la_pkg.sv
// redtin_la_pkg: shared state encoding, default geometry and pointer helpers
// for the Red Tin logic-analyser capture core.
package redtin_la_pkg;

  localparam int DEFAULT_DATA_WIDTH = 128;
  localparam int DEFAULT_DEPTH_LOG2 = 9;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  // Buffer pointers are exactly DEPTH_LOG2 bits so all window arithmetic wraps
  // modulo the buffer depth. Users declare:
  //   typedef logic [ptr_width(DEPTH_LOG2)-1:0] ptr_t;
  function automatic int ptr_width(input int depth_log2);
    return depth_log2;
  endfunction

  // Largest usable pre-trigger depth: keeps the trigger sample and at least one
  // post-trigger sample inside the window.
  function automatic int max_pretrig(input int depth_log2);
    return (1 << depth_log2) - 2;
  endfunction

endpackage

// File: rtl/redtin_la_capture_if.sv
// redtin_la_capture_if: host/probe side bundle of the capture core.
// master = probe + host controller, slave = capture core.
// Optional macro REDTIN_SAMPLE_DIV_EN adds the div sample-rate divider input.
interface redtin_la_capture_if
  import redtin_la_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);

  logic                  arm;
  logic                  clear;
  logic [DEPTH_LOG2-1:0] pretrig;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] trigger_low;
  logic [DATA_WIDTH-1:0] trigger_high;
  logic [DATA_WIDTH-1:0] trigger_rising;
  logic [DATA_WIDTH-1:0] trigger_falling;
  logic                  ext_trigger;
  logic [DEPTH_LOG2-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  busy;
  logic                  triggered;
  logic                  done;
  logic [DEPTH_LOG2-1:0] trig_offset;
`ifdef REDTIN_SAMPLE_DIV_EN
  logic [7:0]            div;
`endif

  modport master (
`ifdef REDTIN_SAMPLE_DIV_EN
    output div,
`endif
    output arm, clear, pretrig, din,
    output trigger_low, trigger_high, trigger_rising, trigger_falling,
    output ext_trigger, read_addr,
    input  read_data, busy, triggered, done, trig_offset
  );

  modport slave (
`ifdef REDTIN_SAMPLE_DIV_EN
    input  div,
`endif
    input  arm, clear, pretrig, din,
    input  trigger_low, trigger_high, trigger_rising, trigger_falling,
    input  ext_trigger, read_addr,
    output read_data, busy, triggered, done, trig_offset
  );

endinterface

// File: rtl/redtin_trigger_match.sv
// redtin_trigger_match: two-stage probe pipeline plus per-bit trigger compare.
// The hit refers to din_buf (the sample presented for writing), so the stored
// trigger sample and the trigger decision are always the same sample.
module redtin_trigger_match
  import redtin_la_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  strobe,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] trigger_low,
  input  logic [DATA_WIDTH-1:0] trigger_high,
  input  logic [DATA_WIDTH-1:0] trigger_rising,
  input  logic [DATA_WIDTH-1:0] trigger_falling,
  input  logic                  ext_trigger,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  hit
);

  logic [DATA_WIDTH-1:0] din_buf_q,  din_buf_d;
  logic [DATA_WIDTH-1:0] din_buf2_q, din_buf2_d;
  logic                  ext_buf_q,  ext_buf_d;
  logic                  ext_pend_q, ext_pend_d;
  logic [DATA_WIDTH-1:0] rise, fall;
  logic                  low_ok, high_ok, rise_ok, fall_ok;

  // Pipeline advance: shift on each sample strobe; an ext pulse between strobes
  // is held pending so it is attached to the next kept sample.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    din_buf_d  = din_buf_q;
    din_buf2_d = din_buf2_q;
    ext_buf_d  = ext_buf_q;
    ext_pend_d = ext_pend_q | ext_trigger;
    if (strobe) begin
      din_buf_d  = din;
      din_buf2_d = din_buf_q;
      ext_buf_d  = ext_pend_q | ext_trigger;
      ext_pend_d = 1'b0;
    end
  end

  // Pipeline registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      din_buf_q  <= '0;
      din_buf2_q <= '0;
      ext_buf_q  <= 1'b0;
      ext_pend_q <= 1'b0;
    end else begin
      din_buf_q  <= din_buf_d;
      din_buf2_q <= din_buf2_d;
      ext_buf_q  <= ext_buf_d;
      ext_pend_q <= ext_pend_d;
    end
  end

  // Mask compare: every enabled bit of every mask must hold, or ext fires.
  always_comb begin
    rise    = din_buf_q & ~din_buf2_q;
    fall    = ~din_buf_q & din_buf2_q;
    low_ok  = ~|(din_buf_q & trigger_low);
    high_ok = ~|(~din_buf_q & trigger_high);
    rise_ok = ~|(~rise & trigger_rising);
    fall_ok = ~|(~fall & trigger_falling);
    hit     = (low_ok & high_ok & rise_ok & fall_ok) | ext_buf_q;
  end

  assign sample = din_buf_q;

endmodule

// File: rtl/redtin_la_capture.sv
// redtin_la_capture: circular-buffer capture core with programmable pre-trigger
// depth and arm/clear handshake. The frozen window is read out in DONE with
// offsets relative to the oldest sample.
// Optional macro REDTIN_SAMPLE_DIV_EN: keep one sample every div+1 clocks.
module redtin_la_capture
  import redtin_la_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input logic               clk,
  input logic               reset,
  redtin_la_capture_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [ptr_width(DEPTH_LOG2)-1:0] ptr_t;
  localparam ptr_t MAX_PRE = ptr_t'(max_pretrig(DEPTH_LOG2));

  state_t                state_q, state_d;
  ptr_t                  wptr_q, wptr_d;
  ptr_t                  cnt_q, cnt_d;
  ptr_t                  trig_ptr_q, trig_ptr_d;
  ptr_t                  eff_q, eff_d;
  logic                  triggered_q, triggered_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  strobe, hit, wr_en, arm_accept;
  logic [DATA_WIDTH-1:0] sample;
  ptr_t                  pre_clamped, post_last, rd_addr;

  assign arm_accept  = (state_q == IDLE) && bus.arm;
  assign pre_clamped = (bus.pretrig > MAX_PRE) ? MAX_PRE : bus.pretrig;
  // Last CAPTURE write index: the window holds eff + 1 + post = DEPTH samples.
  assign post_last   = MAX_PRE - eff_q;

`ifdef REDTIN_SAMPLE_DIV_EN
  logic [7:0] div_q, div_d, div_cnt_q, div_cnt_d;

  // Divider: divisor latched and phase restarted by an accepted arm.
  always_comb begin
    div_d     = div_q;
    div_cnt_d = (div_cnt_q == div_q) ? 8'd0 : div_cnt_q + 8'd1;
    if (arm_accept) begin
      div_d     = bus.div;
      div_cnt_d = 8'd0;
    end
  end

  // Divider registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= 8'd0;
      div_cnt_q <= 8'd0;
    end else begin
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign strobe = (div_cnt_q == div_q);
`else
  assign strobe = 1'b1;
`endif

  redtin_trigger_match #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_match (
    .clk            (clk),
    .reset          (reset),
    .strobe         (strobe),
    .din            (bus.din),
    .trigger_low    (bus.trigger_low),
    .trigger_high   (bus.trigger_high),
    .trigger_rising (bus.trigger_rising),
    .trigger_falling(bus.trigger_falling),
    .ext_trigger    (bus.ext_trigger),
    .sample         (sample),
    .hit            (hit)
  );

  // Capture FSM: next state, pointer/counter updates and the write enable.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    trig_ptr_d  = trig_ptr_q;
    eff_d       = eff_q;
    triggered_d = triggered_q;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_accept) begin
          eff_d       = pre_clamped;
          cnt_d       = '0;
          triggered_d = 1'b0;
          state_d     = (pre_clamped == '0) ? ARMED : FILL;
        end
      end
      FILL: begin
        if (strobe) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == eff_q) state_d = ARMED;
        end
      end
      ARMED: begin
        if (strobe) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (hit) begin
            trig_ptr_d  = wptr_q;
            triggered_d = 1'b1;
            cnt_d       = '0;
            state_d     = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (strobe) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == post_last) state_d = DONE;
        end
      end
      DONE: begin
        // clear has priority; a simultaneous arm is simply not honoured here.
        if (bus.clear) begin
          state_d     = IDLE;
          triggered_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any capture in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      trig_ptr_q  <= '0;
      eff_q       <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      trig_ptr_q  <= trig_ptr_d;
      eff_q       <= eff_d;
      triggered_q <= triggered_d;
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Sample buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset so it maps onto block RAM; only control state is reset.
    if (wr_en) mem[wptr_q] <= sample;
  end

  // Readout addresses are relative to the oldest sample of the frozen window.
  assign rd_addr = trig_ptr_q - eff_q + bus.read_addr;

  // Read port: refresh only in DONE, otherwise hold the last value.
  always_comb begin
    read_data_d = read_data_q;
    if (state_q == DONE) read_data_d = mem[rd_addr];
  end

  // Read data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) read_data_q <= '0;
    else       read_data_q <= read_data_d;
  end

  assign bus.read_data   = read_data_q;
  assign bus.busy        = (state_q == FILL) || (state_q == ARMED) || (state_q == CAPTURE);
  assign bus.done        = (state_q == DONE);
  assign bus.triggered   = triggered_q;
  assign bus.trig_offset = eff_q;

endmodule

// File: tb/tb_redtin_la_capture.sv
// tb_redtin_la_capture: directed and randomized checks of the capture core.
// Each run's stimulus is fully precomputed; the reference model scans that
// stream for the first qualifying sample and derives the window from it.
module tb_redtin_la_capture;

  localparam int DW     = 16;
  localparam int DL     = 4;
  localparam int ARM_AT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int errors = 0;
  int checks = 0;
  int j      = 0;

  logic [DW-1:0] stim_din [256];
  logic          stim_ext [256];
  logic          stim_arm [256];
  logic          stim_clr [256];
  logic [DW-1:0] m_low, m_high, m_rise, m_fall;
  logic [DW-1:0] last_rd [16];

  always #5 clk = ~clk;

  redtin_la_capture_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

  redtin_la_capture #(
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: counter starting at base; mode 1: random words.
  task automatic fill_stim(input int mode, input logic [DW-1:0] base);
    for (int i = 0; i < 256; i++) begin
      stim_din[i] = (mode == 0) ? base + DW'(i) : DW'($urandom);
      stim_ext[i] = 1'b0;
      stim_arm[i] = 1'b0;
      stim_clr[i] = 1'b0;
    end
  endtask

  task automatic set_masks(input logic [DW-1:0] l, h, r, f);
    m_low = l; m_high = h; m_rise = r; m_fall = f;
    bus.trigger_low = l; bus.trigger_high = h;
    bus.trigger_rising = r; bus.trigger_falling = f;
  endtask

  // Apply stimulus index j, advance one clock, sample 1 time unit later.
  task automatic step();
    bus.din         = stim_din[j];
    bus.ext_trigger = stim_ext[j];
    bus.arm         = stim_arm[j];
    bus.clear       = stim_clr[j];
    @(posedge clk);
    #1;
    j++;
  endtask

  // Trigger rule: low bits must be 0, high bits 1, rising bits went 0->1,
  // falling bits went 1->0, all at once; or the external trigger.
  function automatic bit trig_cond(input logic [DW-1:0] cur, input logic [DW-1:0] prev,
                                   input logic ext);
    bit lo, hi, ri, fa;
    lo = (cur & m_low) == '0;
    hi = (cur & m_high) == m_high;
    ri = (cur & ~prev & m_rise) == m_rise;
    fa = (~cur & prev & m_fall) == m_fall;
    return ext || (lo && hi && ri && fa);
  endfunction

  task automatic run_capture(input string tag, input int pre, input bit do_abort);
    int eff, post, k_trig, n_wr, done_edge;
    eff    = (pre > 14) ? 14 : pre;
    post   = 15 - eff;
    k_trig = -1;
    // Written sample k is the probe value presented at the arm edge plus k clocks.
    for (int k = eff; k < 200 && k_trig < 0; k++)
      if (trig_cond(stim_din[ARM_AT+k], stim_din[ARM_AT+k-1], stim_ext[ARM_AT+k])) k_trig = k;
    n_wr = k_trig + post + 1;
    stim_arm[ARM_AT] = 1'b1;
    bus.pretrig = DL'(pre);
    j = 0;
    done_edge = -1;
    while (done_edge < 0 && j < 220) begin
      step();
      if (j - 1 == ARM_AT) begin
        check({tag, "_busy_after_arm"}, bus.busy, 1);
        check({tag, "_trig_after_arm"}, bus.triggered, 0);
      end
      if (j - 1 == ARM_AT + k_trig) check({tag, "_not_yet_triggered"}, bus.triggered, 0);
      if (j - 1 == ARM_AT + k_trig + 1) begin
        check({tag, "_triggered"}, bus.triggered, 1);
        if (do_abort) begin
          reset = 1'b1;
          @(posedge clk);
          #1;
          check({tag, "_abort_busy"}, bus.busy, 0);
          check({tag, "_abort_done"}, bus.done, 0);
          check({tag, "_abort_trig"}, bus.triggered, 0);
          reset = 1'b0;
          return;
        end
      end
      if (bus.done) done_edge = j - 1;
    end
    check({tag, "_done_edge"}, done_edge, ARM_AT + n_wr);
    if (done_edge < 0) begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      return;
    end
    check({tag, "_busy_in_done"}, bus.busy, 0);
    for (int i = 0; i < 16; i++) begin
      bus.read_addr = DL'(i);
      step();
      last_rd[i] = bus.read_data;
      check($sformatf("%s_rd%0d", tag, i), bus.read_data, stim_din[ARM_AT + k_trig - eff + i]);
    end
    check({tag, "_trig_offset"}, bus.trig_offset, eff);
    check({tag, "_done_held"}, bus.done, 1);
    // arm together with clear in DONE: clear wins, arm is dropped.
    stim_arm[j] = 1'b1;
    stim_clr[j] = 1'b1;
    step();
    check({tag, "_cleared_done"}, bus.done, 0);
    check({tag, "_cleared_trig"}, bus.triggered, 0);
    step();
    check({tag, "_arm_dropped"}, bus.busy, 0);
  endtask

  initial begin
    int r1, r2;
    bus.arm = 1'b0; bus.clear = 1'b0; bus.ext_trigger = 1'b0;
    bus.din = '0; bus.pretrig = '0; bus.read_addr = '0;
`ifdef REDTIN_SAMPLE_DIV_EN
    bus.div = 8'd0;
`endif
    set_masks('0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_trig", bus.triggered, 0);
    check("reset_offset", bus.trig_offset, 0);
    check("reset_rdata", bus.read_data, 0);
    reset = 1'b0;

    // Counter probe, trigger on din == 0x10 with 4 pre-trigger samples.
    fill_stim(0, 16'h0000);
    set_masks('0, 16'h0010, '0, '0);
    run_capture("t1", 4, 1'b0);
    check("t1_oldest", last_rd[0], 16'h000C);
    check("t1_trig_sample", last_rd[4], 16'h0010);
    check("t1_newest", last_rd[15], 16'h001B);

    // No pre-trigger, external pulse in the first ARMED cycle.
    fill_stim(0, 16'h0000);
    stim_ext[ARM_AT+1] = 1'b1;
    set_masks('0, 16'h8000, '0, '0);
    run_capture("t2_ext", 0, 1'b0);

    // pretrig above the maximum clamps to 14; odd samples during FILL are ignored.
    fill_stim(0, 16'h0100);
    set_masks('0, 16'h0001, '0, '0);
    run_capture("t3_clamp", 15, 1'b0);

    // Rising edge on bit 0 with bit 0 already high before arm.
    fill_stim(1, 16'h0000);
    for (int i = 0; i < 256; i++) stim_din[i] = {stim_din[i][DW-1:1], (i != 10)};
    set_masks('0, '0, 16'h0001, '0);
    run_capture("t4_rise", 0, 1'b0);

    // Reset during CAPTURE, then a normal capture.
    fill_stim(0, 16'h0000);
    set_masks('0, 16'h0010, '0, '0);
    run_capture("t5_abort", 4, 1'b1);
    fill_stim(0, 16'h0000);
    run_capture("t5_rerun", 4, 1'b0);

    // Random probe data, masks, ext pulses and stray arm/clear while busy.
    for (int r = 0; r < 6; r++) begin
      r1 = $urandom_range(15);
      r2 = (r1 + 1 + $urandom_range(14)) % 16;
      fill_stim(1, 16'h0000);
      for (int i = 0; i < 256; i++) stim_ext[i] = ($urandom_range(31) == 0);
      stim_ext[ARM_AT+60] = 1'b1;
      stim_arm[ARM_AT+3]  = 1'b1;
      stim_clr[ARM_AT+5]  = 1'b1;
      set_masks(DW'(1) << r2, DW'(1) << r1,
                ($urandom_range(1) == 1) ? DW'(1) << $urandom_range(15) : DW'(0), '0);
      run_capture($sformatf("rnd%0d", r), $urandom_range(15), 1'b0);
    end

`ifdef REDTIN_SAMPLE_DIV_EN
    begin : div_test
      int dd;
      fill_stim(0, 16'h0000);
      set_masks(16'h8000, '0, '0, '0);
      bus.div = 8'd2;
      bus.pretrig = '0;
      stim_arm[ARM_AT] = 1'b1;
      j = 0;
      dd = -1;
      while (dd < 0 && j < 120) begin
        step();
        if (bus.done) dd = j - 1;
      end
      check("div_done_edge", (dd >= ARM_AT + 46 && dd <= ARM_AT + 50), 1);
      for (int i = 0; i < 16; i++) begin
        bus.read_addr = DL'(i);
        step();
        last_rd[i] = bus.read_data;
      end
      for (int i = 0; i < 15; i++)
        check($sformatf("div_step%0d", i), last_rd[i+1] - last_rd[i], 16'd3);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
